// File: rtl/result_unpacker_pkg.sv
// Shared types and sizes for the result unpacker.
// Holds default widths, beat count, index width and FSM states.
package result_unpacker_pkg;

    localparam int IN_W_DEF  = 256;
    localparam int OUT_W_DEF = 32;
    localparam int BEATS     = IN_W_DEF / OUT_W_DEF;
    localparam int IDX_W     = $clog2(BEATS);
    localparam int CNT_W     = 16;

    typedef enum logic {
        IDLE = 1'b0,
        SEND = 1'b1
    } state_t;

endpackage

// File: rtl/result_unpacker_if.sv
// Word-in / beat-out handshake bundle for the result unpacker.
// master drives words and downstream busy; slave is the unpacker.
interface result_unpacker_if
    import result_unpacker_pkg::*;
#(
    parameter int IN_W  = IN_W_DEF,
    parameter int OUT_W = OUT_W_DEF
);

    logic             din_vld;
    logic             din_busy;
    logic [IN_W-1:0]  din_data;
    logic             dout_vld;
    logic             dout_busy;
    logic [OUT_W-1:0] dout_data;
    logic             dout_last;
    logic [IDX_W-1:0] dout_idx;
    logic [CNT_W-1:0] word_cnt;

    modport master (
        output din_vld,
        output din_data,
        output dout_busy,
        input  din_busy,
        input  dout_vld,
        input  dout_data,
        input  dout_last,
        input  dout_idx,
        input  word_cnt
    );

    modport slave (
        input  din_vld,
        input  din_data,
        input  dout_busy,
        output din_busy,
        output dout_vld,
        output dout_data,
        output dout_last,
        output dout_idx,
        output word_cnt
    );

endinterface

// File: rtl/result_unpacker.sv
// Splits each wide upstream word into OUT_W beats, lowest beat first.
// The final-beat cycle can accept the next word, so words stream gap-free.
module result_unpacker
    import result_unpacker_pkg::*;
#(
    parameter int IN_W  = IN_W_DEF,
    parameter int OUT_W = OUT_W_DEF
) (
    input logic              clk,
    input logic              rst,
    result_unpacker_if.slave bus
);

    localparam int NB = IN_W / OUT_W;
    localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(NB - 1);

    state_t           state_q;
    logic [IN_W-1:0]  buf_q;
    logic [IDX_W-1:0] idx_q;
    logic [CNT_W-1:0] word_cnt_q;
    logic [CNT_W-1:0] word_cnt_d;

    logic             send;
    logic             last;
    logic             dn_xfer;
    logic             up_xfer;
    logic [OUT_W-1:0] beat;

    // Handshake qualifiers and the currently selected beat.
    always_comb begin
        send    = (state_q == SEND);
        last    = (idx_q == LAST_IDX);
        dn_xfer = send && !bus.dout_busy;
        up_xfer = bus.din_vld && !bus.din_busy;
        beat    = buf_q[int'(idx_q) * OUT_W +: OUT_W];
    end

    // Word counter advances when the final beat leaves.
    always_comb begin
        word_cnt_d = word_cnt_q;
        if (dn_xfer && last) begin
            word_cnt_d = word_cnt_q + CNT_W'(1);
        end
    end

    // Upstream may only load while empty or on the final-beat transfer.
    assign bus.din_busy  = send && !(!bus.dout_busy && last);
    assign bus.dout_vld  = send;
    assign bus.dout_data = send ? beat : '0;
    assign bus.dout_idx  = send ? idx_q : '0;
    assign bus.dout_last = send && last;
    assign bus.word_cnt  = word_cnt_q;

    // FSM: capture a word, walk its beats, reload or go idle at the end.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q    <= IDLE;
            buf_q      <= '0;
            idx_q      <= '0;
            word_cnt_q <= '0;
        end else begin
            word_cnt_q <= word_cnt_d;
            unique case (state_q)
                IDLE: begin
                    if (up_xfer) begin
                        buf_q   <= bus.din_data;
                        idx_q   <= '0;
                        state_q <= SEND;
                    end
                end
                SEND: begin
                    if (dn_xfer) begin
                        if (!last) begin
                            idx_q <= idx_q + IDX_W'(1);
                        end else if (up_xfer) begin
                            buf_q <= bus.din_data;
                            idx_q <= '0;
                        end else begin
                            idx_q   <= '0;
                            state_q <= IDLE;
                        end
                    end
                end
                default: begin
                    state_q <= IDLE;
                    idx_q   <= '0;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_result_unpacker.sv
// Directed bench for result_unpacker: single word, backpressure,
// back-to-back words, reset mid-word and word counter wrap.
module tb_result_unpacker;

    import result_unpacker_pkg::*;

    logic clk = 1'b0;
    logic rst;
    int   n_cmp = 0;
    int   n_err = 0;

    always #5 clk = ~clk;

    result_unpacker_if #(.IN_W(256), .OUT_W(32)) bus ();

    result_unpacker #(
        .IN_W (256),
        .OUT_W(32)
    ) dut (
        .clk(clk),
        .rst(rst),
        .bus(bus)
    );

    task automatic check(string tag, logic [63:0] got, logic [63:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    function automatic logic [255:0] mk_word(logic [31:0] base);
        logic [255:0] w;
        w = '0;
        for (int k = 0; k < 8; k++) begin
            w[k*32 +: 32] = base + 32'(k);
        end
        return w;
    endfunction

    task automatic drive(logic vld, logic [255:0] d, logic busy);
        @(negedge clk);
        bus.din_vld   = vld;
        bus.din_data  = d;
        bus.dout_busy = busy;
        #1;
    endtask

    task automatic beat(string tag, int k, logic [31:0] base, logic bsy);
        logic [31:0] ed;
        logic [2:0]  ei;
        ed = base + 32'(k);
        ei = 3'(k);
        check({tag, "_vld"}, bus.dout_vld, 1'b1);
        check({tag, "_data"}, bus.dout_data, ed);
        check({tag, "_idx"}, bus.dout_idx, ei);
        check({tag, "_last"}, bus.dout_last, k == 7);
        check({tag, "_dbusy"}, bus.din_busy, bsy);
    endtask

    task automatic idle_chk(string tag, logic [15:0] cnt);
        check({tag, "_vld"}, bus.dout_vld, 1'b0);
        check({tag, "_last"}, bus.dout_last, 1'b0);
        check({tag, "_cnt"}, bus.word_cnt, cnt);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1, "watchdog");
    end

    initial begin
        rst           = 1'b1;
        bus.din_vld   = 1'b0;
        bus.din_data  = '0;
        bus.dout_busy = 1'b0;
        #2;
        check("rst_vld", bus.dout_vld, 1'b0);
        check("rst_dbusy", bus.din_busy, 1'b0);
        check("rst_data", bus.dout_data, 32'h0);
        check("rst_idx", bus.dout_idx, 3'h0);
        check("rst_last", bus.dout_last, 1'b0);
        check("rst_cnt", bus.word_cnt, 16'h0);
        @(negedge clk);
        rst = 1'b0;

        // single word, beat k = k+1
        drive(1'b1, mk_word(32'h1), 1'b0);
        check("w1_pre_dbusy", bus.din_busy, 1'b0);
        check("w1_pre_vld", bus.dout_vld, 1'b0);
        for (int k = 0; k < 8; k++) begin
            drive(1'b0, '0, 1'b0);
            beat("w1", k, 32'h1, k != 7);
        end
        drive(1'b0, '0, 1'b0);
        idle_chk("w1_end", 16'd1);

        // backpressure at idx 4, junk offered while busy
        drive(1'b1, mk_word(32'h10), 1'b0);
        for (int k = 0; k < 4; k++) begin
            drive(1'b0, '0, 1'b0);
            beat("bp", k, 32'h10, 1'b1);
        end
        for (int h = 0; h < 3; h++) begin
            drive(1'b1, {8{32'hDEAD_BEEF}}, 1'b1);
            beat("bp_hold", 4, 32'h10, 1'b1);
        end
        drive(1'b0, '0, 1'b0);
        beat("bp_rel", 4, 32'h10, 1'b1);
        for (int k = 5; k < 8; k++) begin
            drive(1'b0, '0, 1'b0);
            beat("bp", k, 32'h10, k != 7);
        end
        drive(1'b0, '0, 1'b0);
        idle_chk("bp_end", 16'd2);

        // back-to-back words, no bubble
        drive(1'b1, mk_word(32'h20), 1'b0);
        for (int k = 0; k < 8; k++) begin
            drive(1'b1, mk_word(32'h30), 1'b0);
            beat("b2b_a", k, 32'h20, k != 7);
        end
        for (int k = 0; k < 8; k++) begin
            drive(1'b0, '0, 1'b0);
            beat("b2b_b", k, 32'h30, k != 7);
            if (k == 0) check("b2b_cnt_mid", bus.word_cnt, 16'd3);
        end
        drive(1'b0, '0, 1'b0);
        idle_chk("b2b_end", 16'd4);

        // reset at idx 3
        drive(1'b1, mk_word(32'h40), 1'b0);
        for (int k = 0; k < 4; k++) begin
            drive(1'b0, '0, 1'b0);
            beat("mr", k, 32'h40, 1'b1);
        end
        rst          = 1'b1;
        bus.din_vld  = 1'b1;
        bus.din_data = mk_word(32'h77);
        #1;
        check("mr_rst_vld", bus.dout_vld, 1'b0);
        check("mr_rst_dbusy", bus.din_busy, 1'b0);
        check("mr_rst_idx", bus.dout_idx, 3'h0);
        check("mr_rst_data", bus.dout_data, 32'h0);
        check("mr_rst_cnt", bus.word_cnt, 16'h0);
        @(posedge clk);
        #1;
        check("mr_hold_vld", bus.dout_vld, 1'b0);
        @(negedge clk);
        rst         = 1'b0;
        bus.din_vld = 1'b0;
        drive(1'b0, '0, 1'b0);
        idle_chk("mr_after", 16'd0);
        drive(1'b1, mk_word(32'h50), 1'b0);
        for (int k = 0; k < 8; k++) begin
            drive(1'b0, '0, 1'b0);
            beat("mr_new", k, 32'h50, k != 7);
        end
        drive(1'b0, '0, 1'b0);
        idle_chk("mr_end", 16'd1);

        // counter preset to 0xFFFF, next word wraps it
        @(negedge clk);
        force dut.word_cnt_q = 16'hFFFF;
        @(posedge clk);
        @(negedge clk);
        release dut.word_cnt_q;
        #1;
        check("wrap_pre", bus.word_cnt, 16'hFFFF);
        drive(1'b1, mk_word(32'h60), 1'b0);
        for (int k = 0; k < 8; k++) begin
            drive(1'b0, '0, 1'b0);
            beat("wrap", k, 32'h60, k != 7);
        end
        check("wrap_last_cnt", bus.word_cnt, 16'hFFFF);
        drive(1'b0, '0, 1'b0);
        idle_chk("wrap_end", 16'h0000);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***",
                 n_cmp, n_err);
        $finish;
    end

endmodule

// File: doc/result_unpacker.md
RESULT_UNPACKER -- requirements
Module: result_unpacker

Interface
REQ-001 Parameter IN_W, default 256, input word width in bits.
REQ-002 Parameter OUT_W, default 32, output beat width in bits; IN_W SHALL be an integer multiple of OUT_W.
REQ-003 Port clk  input  1  sole clock; all state updates on its rising edge.
REQ-004 Port rst  input  1  reset, asynchronous, active-high.
REQ-005 Port din_vld  input  1  upstream word valid.
REQ-006 Port din_busy  output  1  block cannot accept an upstream word this cycle.
REQ-007 Port din_data  input  IN_W  upstream word (the dut's 256-bit dout_data stream).
REQ-008 Port dout_vld  output  1  output beat valid.
REQ-009 Port dout_busy  input  1  downstream cannot accept a beat this cycle.
REQ-010 Port dout_data  output  OUT_W  output beat.
REQ-011 Port dout_last  output  1  current beat is the final beat of its word.
REQ-012 Port dout_idx  output  3  beat index within the word, 0..7.
REQ-013 Port word_cnt  output  16  count of fully emitted words.

Function
REQ-014 Transfer SHALL occur on a rising clk edge where vld=1 and busy=0, on both sides.
REQ-015 Beat k SHALL be din_data[OUT_W*k+OUT_W-1 : OUT_W*k], k=0 first, k=7 last.
REQ-016 FSM SHALL have two states: IDLE (buffer empty) and SEND (buffer holds a word).
REQ-017 IDLE: din_busy=0, dout_vld=0; an upstream transfer SHALL capture din_data, set idx=0, and enter SEND.
REQ-018 SEND: dout_vld=1, dout_data=beat[idx], dout_idx=idx, dout_last=(idx==7).
REQ-019 SEND, downstream transfer with idx<7: idx SHALL increment; with dout_busy=1, beat, idx and buffer SHALL hold unchanged.
REQ-020 SEND, downstream transfer with idx==7: word_cnt SHALL increment (wrapping 0xFFFF->0x0000), and the FSM SHALL return to IDLE unless an upstream word is captured in the same cycle.
REQ-021 din_busy in SEND SHALL be 1 except when dout_vld=1, dout_busy=0 and idx==7 (combinational from dout_busy), which permits back-to-back capture.
REQ-022 A simultaneous last-beat transfer and upstream capture SHALL load the new word, set idx=0, and stay in SEND.
REQ-023 Sustained throughput SHALL be one word per 8 cycles with no bubble cycles between words.
REQ-024 Latency SHALL be one cycle: the first beat is valid the cycle after capture.
REQ-025 din_data SHALL be ignored whenever no upstream transfer occurs.

Reset
REQ-026 Asserting rst SHALL immediately force: state=IDLE, idx=0, word_cnt=0, dout_vld=0, dout_last=0, dout_idx=0, dout_data=0, din_busy=0.
REQ-027 Reset mid-word SHALL discard the buffered word with no further beats emitted, and SHALL NOT increment word_cnt.
REQ-028 No transfer SHALL be recognised on either side while rst=1.

Structure
REQ-029 Shared package SHALL hold IN_W/OUT_W defaults, BEATS=IN_W/OUT_W, the index width, and the two-state FSM enum.
REQ-030 Single flat module with no sub-module: a buffer register, an index counter, a word counter and the FSM.

Verification
REQ-031 Single word: din_data=0x...00000007_..._00000001 (beat k = k+1), dout_busy=0 -> beats 1..8 on 8 consecutive cycles, dout_last only on beat 8, word_cnt=1.
REQ-032 Backpressure: dout_busy=1 for 3 cycles at idx=4 -> beat 5 held stable 4 cycles, no loss or duplication, din_busy=1 throughout.
REQ-033 Back-to-back: two words presented continuously -> din_busy=0 on the word-1 last-beat cycle, word 2 beat 0 on the next cycle, 16 beats in 16 cycles.
REQ-034 Reset mid-word: rst pulse at idx=3 -> dout_vld=0 immediately, word_cnt=0; the next word restarts at beat 0.
REQ-035 Wrap: word_cnt preset by 65535 words -> the next word completes with word_cnt=0x0000.
